// File: rtl/bcd_frequency_entry.sv
// -----------------------------------------------------------------------------
// bcd_frequency_entry
//
// Four-digit BCD frequency entry with an edit cursor, plus a sequential
// BCD-to-binary converter (reverse double-dabble, one bit per clock).
//
// Parameters:
//   FREQUENCY_RANGE  exclusive upper bound of frequency_out (W = clog2 of it)
//   BLINK_DIV        clk cycles per cursor-blink half period
//
// Optional feature macro:
//   FREQ_ENTRY_BLINK_EN  when defined, the digit under the cursor blinks via
//                        digit_blank while idle. When undefined, digit_blank
//                        is tied to 0 and no blink counter exists.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   digit_sel      pulse: advance edit cursor (units -> tens -> ... -> units)
//   digit_inc      pulse: increment digit under cursor (9 wraps to 0)
//   digit_dec      pulse: decrement digit under cursor (0 wraps to 9)
//   commit         pulse: convert the edited value to binary
//   scale_step     pulse: advance scale_out modulo 4 (accepted in any state)
//   bcd_digits     edited value, [3:0] units .. [15:12] thousands
//   cursor         index of the digit under edit, 0 = units
//   digit_blank    per-digit blank mask for the display
//   frequency_out  last committed binary frequency (saturated)
//   freq_valid     one-cycle pulse when frequency_out updates
//   range_err      last commit was out of range and saturated
//   busy           conversion in progress
//   scale_out      scale selection
// -----------------------------------------------------------------------------
module bcd_frequency_entry #(
   parameter int FREQUENCY_RANGE = 8192,
   parameter int BLINK_DIV       = 25000000,
   localparam int W              = $clog2(FREQUENCY_RANGE)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         digit_sel,
   input  logic         digit_inc,
   input  logic         digit_dec,
   input  logic         commit,
   input  logic         scale_step,
   output logic [15:0]  bcd_digits,
   output logic [1:0]   cursor,
   output logic [3:0]   digit_blank,
   output logic [W-1:0] frequency_out,
   output logic         freq_valid,
   output logic         range_err,
   output logic         busy,
   output logic [1:0]   scale_out
);

   // Elaboration-time parameter sanity checks.
   if (FREQUENCY_RANGE < 2) begin : g_bad_range
      $error("FREQUENCY_RANGE must be at least 2");
   end
   if (BLINK_DIV < 1) begin : g_bad_blink
      $error("BLINK_DIV must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_CHECK   = 2'd2
   } state_t;

   // 16 BCD bits shifted into 14 binary bits: 14 shift cycles.
   localparam logic [3:0] NUM_SHIFTS = 4'd14;

   state_t        state_q, state_d;
   logic [29:0]   shift_q;
   logic [3:0]    count_q;
   logic [15:0]   digits_q;
   logic [1:0]    cursor_q;
   logic [1:0]    scale_q;
   logic [W-1:0]  freq_q;
   logic          valid_q;
   logic          err_q;

   logic [3:0]    cur_digit;
   logic [3:0]    new_digit;
   logic [13:0]   result;

   // One reverse double-dabble step: shift right, then any BCD field that
   // now holds >= 8 received a bit worth 5 (half of 10) but weighted 8, so
   // subtract 3 to correct it.
   function automatic logic [29:0] dabble_step(input logic [29:0] r);
      logic [29:0] s;
      s = r >> 1;
      for (int i = 0; i < 4; i++) begin
         if (s[14 + 4*i +: 4] >= 4'd8)
            s[14 + 4*i +: 4] = s[14 + 4*i +: 4] - 4'd3;
      end
      return s;
   endfunction

   assign cur_digit = digits_q[{cursor_q, 2'b00} +: 4];
   assign new_digit = digit_inc ? ((cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1)
                                : ((cur_digit == 4'd0) ? 4'd9 : cur_digit - 4'd1);
   assign result    = shift_q[13:0];

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is always assigned with non-blocking (<=) so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // ---------------------------------------------------------------------------
   // FSM next-state and status outputs
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path through
   // the case can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      busy    = 1'b1;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (commit) state_d = S_CONVERT;
         end
         S_CONVERT: begin
            if (count_q == 4'd1) state_d = S_CHECK;
         end
         S_CHECK: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Edit registers, converter datapath and result registers
   // ---------------------------------------------------------------------------
   // NOTE: the datapath registers are reset too; they are few and narrow, and
   // it keeps the converter free of X state if it is ever observed early.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q  <= '0;
         count_q  <= '0;
         digits_q <= '0;
         cursor_q <= '0;
         scale_q  <= '0;
         freq_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         scale_q <= scale_q + 2'(scale_step);
         case (state_q)
            S_IDLE: begin
               if (commit) begin
                  // Commit wins over any same-cycle edit: the pre-edit digits
                  // are converted and the edit is dropped.
                  shift_q <= {digits_q, 14'b0};
                  count_q <= NUM_SHIFTS;
               end else begin
                  // inc and dec together cancel out.
                  if (digit_inc ^ digit_dec)
                     digits_q[{cursor_q, 2'b00} +: 4] <= new_digit;
                  // Cursor moves after the digit at the old cursor is edited.
                  if (digit_sel)
                     cursor_q <= cursor_q + 2'd1;
               end
            end
            S_CONVERT: begin
               shift_q <= dabble_step(shift_q);
               count_q <= count_q - 4'd1;
            end
            S_CHECK: begin
               valid_q <= 1'b1;
               if (int'(result) >= FREQUENCY_RANGE) begin
                  freq_q <= W'(FREQUENCY_RANGE - 1);
                  err_q  <= 1'b1;
               end else begin
                  freq_q <= W'(result);
                  err_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bcd_digits    = digits_q;
   assign cursor        = cursor_q;
   assign frequency_out = freq_q;
   assign freq_valid    = valid_q;
   assign range_err     = err_q;
   assign scale_out     = scale_q;

   // ---------------------------------------------------------------------------
   // Cursor blink
   // ---------------------------------------------------------------------------
`ifdef FREQ_ENTRY_BLINK_EN
   localparam int CW = $clog2(BLINK_DIV + 1);

   logic [CW-1:0] blink_cnt_q;
   logic          blink_phase_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= ~blink_phase_q;
      end else begin
         blink_cnt_q   <= blink_cnt_q + CW'(1);
      end
   end

   // Only the digit under edit blinks, and only while edits are accepted.
   assign digit_blank = (state_q == S_IDLE) ? (4'(blink_phase_q) << cursor_q) : 4'b0000;
`else
   assign digit_blank = 4'b0000;
`endif

endmodule

// File: tb/tb_bcd_frequency_entry.sv
// -----------------------------------------------------------------------------
// tb_bcd_frequency_entry
//
// Directed bench for bcd_frequency_entry. A small decimal model of the edited
// digits predicts bcd_digits/cursor; each commit pushes its expected
// {range_err, frequency_out} to a scoreboard queue that is popped when
// freq_valid pulses. Build with FREQ_ENTRY_BLINK_EN defined to exercise the
// blink path (BLINK_DIV = 4).
// -----------------------------------------------------------------------------
module tb_bcd_frequency_entry;

   localparam int FR = 8192;
   localparam int W  = $clog2(FR);
   localparam int BD = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          digit_sel, digit_inc, digit_dec, commit, scale_step;
   logic [15:0]   bcd_digits;
   logic [1:0]    cursor;
   logic [3:0]    digit_blank;
   logic [W-1:0]  frequency_out;
   logic          freq_valid;
   logic          range_err;
   logic          busy;
   logic [1:0]    scale_out;

   int vectors     = 0;
   int miscompares = 0;

   logic [W:0] sb[$];   // {range_err, frequency_out}
   int m_dig[4];
   int m_cur;
   int m_scale;

   always #5 clk = ~clk;

   bcd_frequency_entry #(
      .FREQUENCY_RANGE (FR),
      .BLINK_DIV       (BD)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .digit_sel     (digit_sel),
      .digit_inc     (digit_inc),
      .digit_dec     (digit_dec),
      .commit        (commit),
      .scale_step    (scale_step),
      .bcd_digits    (bcd_digits),
      .cursor        (cursor),
      .digit_blank   (digit_blank),
      .frequency_out (frequency_out),
      .freq_valid    (freq_valid),
      .range_err     (range_err),
      .busy          (busy),
      .scale_out     (scale_out)
   );

   // One active edge, then settle 1 ns so outputs are sampled off the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_bcd();
      return {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
   endfunction

   function automatic int model_value();
      return m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_dig[i] = 0;
      m_cur   = 0;
      m_scale = 0;
   endtask

   // Single idle-cycle pulse of edit/scale inputs, with the model updated.
   task automatic pulse(input logic sel, input logic inc, input logic dec, input logic scl);
      digit_sel = sel; digit_inc = inc; digit_dec = dec; scale_step = scl;
      step();
      digit_sel = 1'b0; digit_inc = 1'b0; digit_dec = 1'b0; scale_step = 1'b0;
      if (inc && !dec) m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
      if (dec && !inc) m_dig[m_cur] = (m_dig[m_cur] + 9) % 10;
      if (sel) m_cur = (m_cur + 1) % 4;
      if (scl) m_scale = (m_scale + 1) % 4;
   endtask

   task automatic set_digit(input int idx, input int target);
      for (int k = 0; k < 4 && m_cur != idx; k++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 10 && m_dig[idx] != target; k++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
      chk("set_digit_bcd", 32'(bcd_digits), 32'(model_bcd()));
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_bcd"},    32'(bcd_digits),    32'h0);
      chk({tag, "_cursor"}, 32'(cursor),        32'h0);
      chk({tag, "_blank"},  32'(digit_blank),   32'h0);
      chk({tag, "_freq"},   32'(frequency_out), 32'h0);
      chk({tag, "_valid"},  32'(freq_valid),    32'h0);
      chk({tag, "_err"},    32'(range_err),     32'h0);
      chk({tag, "_busy"},   32'(busy),          32'h0);
      chk({tag, "_scale"},  32'(scale_out),     32'h0);
   endtask

   // Commit the modelled value (optionally with a same-cycle digit_inc that
   // must be discarded) and check latency, pulse width and result.
   task automatic run_commit(input string tag, input logic with_inc);
      int         v;
      bit         got;
      logic [W:0] exp;
      v   = model_value();
      exp = (v >= FR) ? {1'b1, W'(FR - 1)} : {1'b0, W'(v)};
      sb.push_back(exp);
      commit = 1'b1; digit_inc = with_inc;
      step();                                   // edge 0
      commit = 1'b0; digit_inc = 1'b0;
      chk({tag, "_busy_e0"}, 32'(busy), 32'h1);
      got = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         step();                                // edge e
         if (e == 14) chk({tag, "_busy_e14"}, 32'(busy), 32'h1);
         if (freq_valid) begin
            got = 1'b1;
            chk({tag, "_latency"}, 32'(e), 32'd15);
            if (sb.size() > 0) begin
               exp = sb.pop_front();
               chk({tag, "_freq"}, 32'(frequency_out), 32'(exp[W-1:0]));
               chk({tag, "_err"},  32'(range_err),     32'(exp[W]));
            end else begin
               chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'h1);
            end
            break;
         end
      end
      chk({tag, "_valid_seen"}, 32'(got), 32'h1);
      step();                                   // edge 16
      chk({tag, "_valid_drop"}, 32'(freq_valid), 32'h0);
      chk({tag, "_busy_done"},  32'(busy),       32'h0);
      chk({tag, "_bcd_kept"},   32'(bcd_digits), 32'(model_bcd()));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         vcount;
      int         trans;
      int         last_t;
      logic [3:0] prev;

      reset = 1'b1;
      digit_sel = 1'b0; digit_inc = 1'b0; digit_dec = 1'b0;
      commit = 1'b0; scale_step = 1'b0;
      model_reset();
      step();
      step();
      check_reset_state("reset");
      reset = 1'b0;

      // Digit wrap and cursor cycle.
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      chk("dec_wrap", 32'(bcd_digits), 32'h0009);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      chk("inc_wrap", 32'(bcd_digits), 32'h0000);
      for (int i = 1; i <= 4; i++) begin
         pulse(1'b1, 1'b0, 1'b0, 1'b0);
         chk("cursor_step", 32'(cursor), 32'(i % 4));
      end

      // inc and dec together: no change.
      pulse(1'b0, 1'b1, 1'b1, 1'b0);
      chk("inc_dec_same", 32'(bcd_digits), 32'h0000);

      // Thousands = 1 -> 1000.
      set_digit(3, 1);
      chk("bcd_1000", 32'(bcd_digits), 32'h1000);
      run_commit("c1000", 1'b0);
      chk("freq_1000_abs", 32'(frequency_out), 32'd1000);

      // 9999 saturates, then 0042 is in range.
      for (int i = 0; i < 4; i++) set_digit(i, 9);
      chk("bcd_9999", 32'(bcd_digits), 32'h9999);
      run_commit("c9999", 1'b0);
      chk("freq_sat_abs", 32'(frequency_out), 32'd8191);
      set_digit(3, 0);
      set_digit(2, 0);
      set_digit(1, 4);
      set_digit(0, 2);
      run_commit("c0042", 1'b0);
      chk("freq_42_abs", 32'(frequency_out), 32'd42);
      chk("err_42_abs",  32'(range_err),     32'd0);

      // Commit with same-cycle digit_inc: converts 0044, digit stays 4.
      set_digit(0, 4);
      run_commit("c_inc", 1'b1);
      chk("inc_commit_bcd", 32'(bcd_digits), 32'h0044);

      // digit_sel + digit_inc: edit old cursor, then advance.
      pulse(1'b1, 1'b1, 1'b0, 1'b0);
      chk("sel_inc_bcd",    32'(bcd_digits), 32'h0045);
      chk("sel_inc_cursor", 32'(cursor),     32'h1);

      // Scale stepping while idle.
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      chk("scale_idle", 32'(scale_out), 32'(m_scale));

      // Commit, ignored pulses at edge 5, reset at edge 7.
      commit = 1'b1; step(); commit = 1'b0;     // edge 0
      step(); step();                           // edges 1, 2
      scale_step = 1'b1; step(); scale_step = 1'b0; m_scale = (m_scale + 1) % 4;  // edge 3
      chk("scale_busy", 32'(scale_out), 32'(m_scale));
      step();                                   // edge 4
      digit_inc = 1'b1; commit = 1'b1; step(); digit_inc = 1'b0; commit = 1'b0;  // edge 5
      chk("busy_edit_ignored", 32'(bcd_digits), 32'(model_bcd()));
      chk("busy_at_e5",        32'(busy),       32'h1);
      step();                                   // edge 6
      reset = 1'b1; step(); reset = 1'b0;       // edge 7
      model_reset();
      check_reset_state("abort");
      vcount = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (freq_valid) vcount++;
      end
      chk("abort_no_valid", 32'(vcount), 32'h0);
      chk("abort_freq",     32'(frequency_out), 32'h0);

      // Cursor blink on digit 2.
      set_digit(2, 0);
      chk("blink_cursor", 32'(cursor), 32'h2);
      prev   = digit_blank;
      trans  = 0;
      last_t = -1;
      for (int t = 0; t < 24; t++) begin
         step();
`ifdef FREQ_ENTRY_BLINK_EN
         chk("blink_mask", 32'(digit_blank & 4'b1011), 32'h0);
         if (digit_blank != prev) begin
            if (last_t >= 0) chk("blink_period", 32'(t - last_t), 32'(BD));
            last_t = t;
            trans++;
         end
         prev = digit_blank;
`else
         if (t % 4 == 0) chk("blink_off", 32'(digit_blank), 32'h0);
`endif
      end
`ifdef FREQ_ENTRY_BLINK_EN
      chk("blink_transitions", 32'(trans), 32'd6);
`endif

      chk("sb_drained", 32'(sb.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
